// File: rtl/sent_rx_decoder.sv
// SENT (SAE J2716) receiver. Measures the time between falling edges, locks
// on the sync pulse, decodes the status/data/CRC nibbles and checks the CRC.
// It also assembles the 16-frame short serial message from status bits 3/2.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_HUNT   | waiting for a sync interval (56 +/- SYNC_TOL ticks)
// S_STATUS | sync seen, next interval is the status nibble
// S_DATA   | collecting NUM_DATA data nibbles
// S_CRC    | next interval is the CRC nibble; frame ends there
`timescale 1ns/1ps
module sent_rx_decoder #(
  parameter int CLK_PER_TICK = 8,
  parameter int NUM_DATA     = 6,
  parameter int SYNC_TOL     = 2,
  parameter int MAX_TICKS    = 800
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        enable_i,
  input  logic        sent_i,
  output logic        frame_valid_o,
  output logic        crc_error_o,
  output logic        frame_error_o,
  output logic [3:0]  status_nibble_o,
  output logic [23:0] data_out_o,
  output logic        short_valid_o,
  output logic [3:0]  short_id_o,
  output logic [7:0]  short_data_o,
  output logic [3:0]  short_crc_o
);

  localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam int TW = $clog2(MAX_TICKS + 1);
  localparam int DW = 4 * NUM_DATA;
  localparam int IW = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1;

  localparam logic [PW-1:0] PRESC_START = PW'(CLK_PER_TICK / 2);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_PER_TICK - 1);
  localparam logic [TW-1:0] TICK_MAX    = TW'(MAX_TICKS);
  localparam logic [TW-1:0] SYNC_LO     = TW'(56 - SYNC_TOL);
  localparam logic [TW-1:0] SYNC_HI     = TW'(56 + SYNC_TOL);
  localparam logic [TW-1:0] NIB_LO      = TW'(12);
  localparam logic [TW-1:0] NIB_HI      = TW'(27);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_DATA - 1);

  typedef enum logic [1:0] {S_HUNT, S_STATUS, S_DATA, S_CRC} state_e;

  logic [2:0]    sync_q;
  logic          fall_d;
  logic [PW-1:0] presc_q;
  logic [TW-1:0] tick_q;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [3:0]    crc_q;
  logic [3:0]    stat_q;
  logic [DW-1:0] dsh_q;
  logic          msg_act_q;
  logic [3:0]    bit_cnt_q;
  logic [15:0]   msg_q;

  logic          fv_q, ce_q, fe_q, sv_q;
  logic [3:0]    status_q;
  logic [23:0]   data_q;
  logic [3:0]    sid_q;
  logic [7:0]    sdata_q;
  logic [3:0]    scrc_q;

  logic          is_sync_d, is_nib_d;
  logic [3:0]    nib_d;
  logic [3:0]    crc_final_d;
  logic [15:0]   msg_next_d;

  // J2716 recommended 4-bit CRC lookup table
  function automatic logic [3:0] crc_tab(input logic [3:0] idx);
    logic [3:0] r;
    case (idx)
      4'd0:    r = 4'd0;
      4'd1:    r = 4'd13;
      4'd2:    r = 4'd7;
      4'd3:    r = 4'd10;
      4'd4:    r = 4'd14;
      4'd5:    r = 4'd3;
      4'd6:    r = 4'd9;
      4'd7:    r = 4'd4;
      4'd8:    r = 4'd1;
      4'd9:    r = 4'd12;
      4'd10:   r = 4'd6;
      4'd11:   r = 4'd11;
      4'd12:   r = 4'd15;
      4'd13:   r = 4'd2;
      4'd14:   r = 4'd8;
      default: r = 4'd5;
    endcase
    return r;
  endfunction

  // two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) sync_q <= 3'b111;
    else           sync_q <= {sync_q[1:0], sent_i};
  end

  assign fall_d = sync_q[2] & ~sync_q[1];

  // interval timer: prescaler starts half a tick in so the count rounds
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      presc_q <= '0;
      tick_q  <= '0;
    end else if (fall_d) begin
      presc_q <= PRESC_START;
      tick_q  <= '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
      if (tick_q != TICK_MAX) tick_q <= tick_q + TW'(1);
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // interval classification and per-nibble helpers
  always_comb begin
    is_sync_d   = (tick_q >= SYNC_LO) && (tick_q <= SYNC_HI);
    is_nib_d    = (tick_q >= NIB_LO) && (tick_q <= NIB_HI);
    nib_d       = 4'(tick_q - NIB_LO);
    crc_final_d = crc_tab(crc_q);
    msg_next_d  = {msg_q[14:0], stat_q[2]};
  end

  // frame FSM with registered strobes, held outputs and short-message assembly
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_HUNT;
      idx_q     <= '0;
      crc_q     <= '0;
      stat_q    <= '0;
      dsh_q     <= '0;
      msg_act_q <= 1'b0;
      bit_cnt_q <= '0;
      msg_q     <= '0;
      fv_q      <= 1'b0;
      ce_q      <= 1'b0;
      fe_q      <= 1'b0;
      sv_q      <= 1'b0;
      status_q  <= '0;
      data_q    <= '0;
      sid_q     <= '0;
      sdata_q   <= '0;
      scrc_q    <= '0;
    end else begin
      fv_q <= 1'b0;
      ce_q <= 1'b0;
      fe_q <= 1'b0;
      sv_q <= 1'b0;
      if (!enable_i) begin
        state_q   <= S_HUNT;
        msg_act_q <= 1'b0;
      end else if (state_q != S_HUNT && !fall_d && tick_q == TICK_MAX) begin
        fe_q      <= 1'b1;
        state_q   <= S_HUNT;
        msg_act_q <= 1'b0;
      end else if (fall_d) begin
        if (state_q == S_HUNT) begin
          if (is_sync_d) state_q <= S_STATUS;
        end else if (is_sync_d) begin
          // a sync in the middle of a frame restarts reception from it
          fe_q      <= 1'b1;
          state_q   <= S_STATUS;
          msg_act_q <= 1'b0;
        end else if (!is_nib_d) begin
          fe_q      <= 1'b1;
          state_q   <= S_HUNT;
          msg_act_q <= 1'b0;
        end else begin
          case (state_q)
            S_STATUS: begin
              stat_q  <= nib_d;
              idx_q   <= '0;
              crc_q   <= 4'd5;
              state_q <= S_DATA;
            end
            S_DATA: begin
              dsh_q <= (dsh_q << 4) | DW'(nib_d);
              crc_q <= nib_d ^ crc_tab(crc_q);
              idx_q <= idx_q + IW'(1);
              if (idx_q == IDX_LAST) state_q <= S_CRC;
            end
            S_CRC: begin
              state_q <= S_HUNT;
              if (crc_final_d == nib_d) begin
                fv_q     <= 1'b1;
                status_q <= stat_q;
                data_q   <= 24'(dsh_q);
                if (stat_q[3]) begin
                  msg_q     <= {15'd0, stat_q[2]};
                  bit_cnt_q <= '0;
                  msg_act_q <= 1'b1;
                end else if (msg_act_q) begin
                  if (bit_cnt_q == 4'd14) begin
                    sv_q      <= 1'b1;
                    sid_q     <= msg_next_d[15:12];
                    sdata_q   <= msg_next_d[11:4];
                    scrc_q    <= msg_next_d[3:0];
                    msg_act_q <= 1'b0;
                    bit_cnt_q <= '0;
                  end else begin
                    msg_q     <= msg_next_d;
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                  end
                end
              end else begin
                ce_q      <= 1'b1;
                msg_act_q <= 1'b0;
              end
            end
            default: state_q <= S_HUNT;
          endcase
        end
      end
    end
  end

  assign frame_valid_o   = fv_q;
  assign crc_error_o     = ce_q;
  assign frame_error_o   = fe_q;
  assign status_nibble_o = status_q;
  assign data_out_o      = data_q;
  assign short_valid_o   = sv_q;
  assign short_id_o      = sid_q;
  assign short_data_o    = sdata_q;
  assign short_crc_o     = scrc_q;

endmodule

// File: tb/tb_sent_rx_decoder.sv
// Testbench for sent_rx_decoder: interval-level stimulus, queue-based frame
// reference model, scoreboard monitor that checks each strobe as it appears.
`timescale 1ns/1ps
module tb_sent_rx_decoder;

  localparam int K    = 4;
  localparam int ND   = 6;
  localparam int MAXT = 800;

  logic        clk = 1'b0;
  logic        reset_n, enable, sent;
  logic        frame_valid, crc_error, frame_error, short_valid;
  logic [3:0]  status_nibble, short_id, short_crc;
  logic [23:0] data_out;
  logic [7:0]  short_data;

  always #5 clk = ~clk;

  sent_rx_decoder #(.CLK_PER_TICK(K), .NUM_DATA(ND), .SYNC_TOL(2), .MAX_TICKS(MAXT)) dut (
    .clk_i(clk), .reset_ni(reset_n), .enable_i(enable), .sent_i(sent),
    .frame_valid_o(frame_valid), .crc_error_o(crc_error), .frame_error_o(frame_error),
    .status_nibble_o(status_nibble), .data_out_o(data_out),
    .short_valid_o(short_valid), .short_id_o(short_id),
    .short_data_o(short_data), .short_crc_o(short_crc)
  );

  typedef struct {
    int          kind;   // 0 good frame, 1 crc error, 2 frame error
    bit          lat;    // strobe is tied to a pin edge
    logic [3:0]  st;
    logic [23:0] data;
    bit          sv;
    logic [15:0] smsg;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0, miscompares = 0;
  int   cyc = 0, fall_cyc = 0;
  int   T[16] = '{0, 13, 7, 10, 14, 3, 9, 4, 1, 12, 6, 11, 15, 2, 8, 5};

  // reference model state
  bit          locked = 1'b0;
  int          nibs[$];
  bit          msg_on = 1'b0;
  bit          msg_bits[$];
  logic [3:0]  good_st = '0;
  logic [23:0] good_data = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int crc_of(input logic [23:0] d);
    int c = 5;
    for (int i = 0; i < ND; i++) c = int'(d[23-4*i -: 4]) ^ T[c];
    return T[c];
  endfunction

  function automatic void model_reset(input bit full);
    locked = 1'b0;
    nibs.delete();
    msg_on = 1'b0;
    msg_bits.delete();
    if (full) begin
      good_st   = '0;
      good_data = '0;
    end
  endfunction

  function automatic void push_err(input int kind, input bit lat);
    exp_t e;
    e.kind = kind; e.lat = lat; e.st = good_st; e.data = good_data; e.sv = 1'b0; e.smsg = '0;
    expq.push_back(e);
  endfunction

  // outcome of one falling-edge-to-falling-edge interval of t ticks
  function automatic void model_interval(input int t);
    exp_t        e;
    logic [23:0] d;
    logic [3:0]  st;
    bit          sync = (t >= 54 && t <= 58);
    if (!locked) begin
      if (sync) begin locked = 1'b1; nibs.delete(); end
      return;
    end
    if (t >= MAXT) begin
      push_err(2, 1'b0); locked = 1'b0; msg_on = 1'b0; msg_bits.delete(); return;
    end
    if (sync) begin
      push_err(2, 1'b1); nibs.delete(); msg_on = 1'b0; msg_bits.delete(); return;
    end
    if (t < 12 || t > 27) begin
      push_err(2, 1'b1); locked = 1'b0; msg_on = 1'b0; msg_bits.delete(); return;
    end
    nibs.push_back(t - 12);
    if (nibs.size() < ND + 2) return;
    locked = 1'b0;
    d = '0;
    for (int i = 1; i <= ND; i++) d = {d[19:0], 4'(nibs[i])};
    st = 4'(nibs[0]);
    if (crc_of(d) != nibs[ND+1]) begin
      push_err(1, 1'b1); msg_on = 1'b0; msg_bits.delete(); return;
    end
    good_st = st; good_data = d;
    e.kind = 0; e.lat = 1'b1; e.st = st; e.data = d; e.sv = 1'b0; e.smsg = '0;
    if (st[3]) begin
      msg_bits.delete(); msg_bits.push_back(st[2]); msg_on = 1'b1;
    end else if (msg_on) begin
      msg_bits.push_back(st[2]);
      if (msg_bits.size() == 16) begin
        e.sv = 1'b1;
        for (int i = 0; i < 16; i++) e.smsg[15-i] = msg_bits[i];
        msg_on = 1'b0; msg_bits.delete();
      end
    end
    expq.push_back(e);
  endfunction

  // one SENT interval: falling edge, 4 ticks low, rest high
  task automatic pulse(input int ticks);
    sent = 1'b0;
    fall_cyc = cyc;
    model_interval(ticks);
    repeat (4*K) @(negedge clk);
    sent = 1'b1;
    repeat ((ticks-4)*K) @(negedge clk);
  endtask

  task automatic send_ints(input int q[$]);
    foreach (q[i]) pulse(q[i]);
  endtask

  task automatic send_frame(input int sync, input int st, input logic [23:0] d, input int crc);
    int q[$];
    q = {sync, 12 + st};
    for (int i = 0; i < ND; i++) q.push_back(12 + int'(d[23-4*i -: 4]));
    q.push_back(12 + crc);
    send_ints(q);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] es;
    if (reset_n && (frame_valid || crc_error || frame_error || short_valid)) begin
      if (expq.size() == 0) begin
        check("unexpected_strobe", {28'd0, frame_valid, crc_error, frame_error, short_valid}, 32'd0);
      end else begin
        e  = expq.pop_front();
        es = (e.kind == 0) ? {3'b100, e.sv} : (e.kind == 1) ? 4'b0100 : 4'b0010;
        check("strobes", {28'd0, frame_valid, crc_error, frame_error, short_valid}, {28'd0, es});
        if (e.lat) check("latency", cyc - fall_cyc, 3);
        check("status_nibble", status_nibble, e.st);
        check("data_out", data_out, e.data);
        if (e.sv) begin
          check("short_id", short_id, e.smsg[15:12]);
          check("short_data", short_data, e.smsg[11:4]);
          check("short_crc", short_crc, e.smsg[3:0]);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          q[$];
    int          st, sync, crc, r;
    logic [23:0] d;
    logic [15:0] stream;

    reset_n = 1'b0; enable = 1'b1; sent = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_crc_error", crc_error, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_short_valid", short_valid, 0);
    check("rst_status", status_nibble, 0);
    check("rst_data", data_out, 0);
    check("rst_short_fields", {16'd0, short_id, short_data, short_crc}, 0);
    reset_n = 1'b1;
    model_reset(1'b1);
    repeat (3) @(negedge clk);

    // ideal frame, a different good frame, then ideal with bad CRC
    send_frame(56, 8, 24'h000000, 5);
    send_frame(56, 3, 24'h123456, crc_of(24'h123456));
    send_frame(56, 8, 24'h000000, 4);
    // illegal 30-tick data nibble, then a clean frame
    send_ints('{56, 15, 13, 30, 14, 15, 16, 17, 18});
    send_frame(56, 2, 24'hABCDEF, crc_of(24'hABCDEF));
    // sync tolerance and long pause
    send_frame(57, 6, 24'h0F0F0F, crc_of(24'h0F0F0F));
    send_frame(60, 1, 24'h111111, crc_of(24'h111111));
    pulse(300);
    send_frame(56, 4, 24'hFEDCBA, crc_of(24'hFEDCBA));
    // timeout mid-frame
    pulse(56); pulse(20); pulse(820);
    send_frame(56, 5, 24'h5A5A5A, crc_of(24'h5A5A5A));

    // short serial message 0x5A3C
    stream = 16'h5A3C;
    for (int f = 0; f < 16; f++) begin
      st = ((f == 0) ? 8 : 0) | (int'(stream[15-f]) << 2) | int'($urandom_range(0, 3));
      d  = $urandom & 24'h333333;
      send_frame(56, st, d, crc_of(d));
    end
    pulse(100);

    // message interrupted by enable drop in frame 10
    for (int f = 0; f < 16; f++) begin
      st = ((f == 0) ? 8 : 0) | (int'($urandom_range(0, 1)) << 2);
      d  = $urandom & 24'h333333;
      if (f == 10) begin
        pulse(56); pulse(12 + st); pulse(12 + int'(d[23:20]));
        fork
          pulse(12 + int'(d[19:16]));
          begin
            repeat (6*K) @(negedge clk);
            enable = 1'b0;
            model_reset(1'b0);
            repeat (3*K) @(negedge clk);
            enable = 1'b1;
          end
        join
        for (int i = 2; i < ND; i++) pulse(12 + int'(d[23-4*i -: 4]));
        pulse(12 + crc_of(d));
      end else begin
        send_frame(56, st, d, crc_of(d));
      end
    end
    send_frame(56, 9, 24'h246813, crc_of(24'h246813));
    pulse(100);

    // reset pulse mid-DATA
    pulse(56); pulse(15);
    fork
      pulse(21);
      begin
        repeat (6*K) @(negedge clk);
        reset_n = 1'b0;
        model_reset(1'b1);
        repeat (2) @(negedge clk);
        check("midrst_status", status_nibble, 0);
        check("midrst_data", data_out, 0);
        reset_n = 1'b1;
      end
    join
    send_ints('{13, 13, 13, 13, 13});
    send_frame(56, 7, 24'h9E3701, crc_of(24'h9E3701));
    pulse(100);

    // randomized frames
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 9) == 0) pulse($urandom_range(80, 400));
      r    = $urandom_range(0, 9);
      sync = (r == 0) ? $urandom_range(60, 70) : $urandom_range(54, 58);
      st   = $urandom_range(0, 15);
      d    = $urandom;
      crc  = crc_of(d);
      if ($urandom_range(0, 3) == 0) crc = (crc + $urandom_range(1, 15)) % 16;
      q = {sync, 12 + st};
      for (int i = 0; i < ND; i++) q.push_back(12 + int'(d[23-4*i -: 4]));
      q.push_back(12 + crc);
      if ($urandom_range(0, 6) == 0)
        q[$urandom_range(1, 8)] = ($urandom_range(0, 1) == 1) ? $urandom_range(6, 11) : $urandom_range(28, 45);
      else if ($urandom_range(0, 19) == 0)
        q[$urandom_range(2, 7)] = 56;
      send_ints(q);
    end
    pulse(100);

    repeat (50) @(negedge clk);
    check("queue_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
